// File: rtl/hot_bit_pkg.sv
// rtl/hot_bit_pkg.sv - shared defaults, index width helper and result types for the hot-bit encoder
package hot_bit_pkg;

   localparam int DEFAULT_DEPTH = 8;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int RES_IDX_W = idx_width(DEFAULT_DEPTH);

   // Index field is sized for the default depth; narrower instances zero-extend into it.
   typedef struct packed {
      logic [RES_IDX_W-1:0] index;
      logic                 zero;
      logic                 multi;
   } result_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/hot_bit_prio_enc.sv
// rtl/hot_bit_prio_enc.sv - combinational lowest-bit-wins encoder with zero/multi flags
module hot_bit_prio_enc
   import hot_bit_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int IDX_W = idx_width(DEPTH)
) (
   input  logic [DEPTH-1:0] onehot,
   output logic [IDX_W-1:0] index,
   output logic             zero,
   output logic             multi
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      index = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (onehot[i]) begin
            index = IDX_W'(i);
         end
      end
      zero  = (onehot == '0);
      multi = ((onehot & (onehot - DEPTH'(1))) != '0);
   end

endmodule

// File: rtl/hot_bit_encoder.sv
// rtl/hot_bit_encoder.sv - one-hot encoder feeding a 2-entry result FIFO with malformed-word counter
module hot_bit_encoder
   import hot_bit_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int IDX_W = idx_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DEPTH-1:0] onehot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] index,
   output logic             zero,
   output logic             multi,
   output logic [15:0]      err_count,
   input  logic             clr_count
);

   logic [IDX_W-1:0] enc_index;
   logic             enc_zero;
   logic             enc_multi;
   result_t          enc_res;

   fifo_state_t      state_q;
   result_t          head_q;
   result_t          tail_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [15:0]      err_q;
   logic [15:0]      err_d;
   logic             push;
   logic             pop;

   hot_bit_prio_enc #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .onehot (onehot),
      .index  (enc_index),
      .zero   (enc_zero),
      .multi  (enc_multi)
   );

   assign enc_res.index = RES_IDX_W'(enc_index);
   assign enc_res.zero  = enc_zero;
   assign enc_res.multi = enc_multi;

   assign push = in_valid && in_ready_q;
   assign pop  = out_valid_q && out_ready;

   // Handshake flags are updated alongside the state so in_ready never sees out_ready combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  head_q      <= enc_res;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_q <= enc_res;
               end else if (push) begin
                  tail_q     <= enc_res;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (pop) begin
                  head_q      <= '0;
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  head_q     <= tail_q;
                  state_q    <= ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               head_q      <= '0;
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      err_d = err_q;
      if (clr_count) begin
         err_d = '0;
      end else if (push && (enc_zero || enc_multi) && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign index     = head_q.index[IDX_W-1:0];
   assign zero      = head_q.zero;
   assign multi     = head_q.multi;
   assign err_count = err_q;

endmodule

// File: doc/hot_bit_encoder.md
HOT_BIT_ENCODER -- requirements
Module: hot_bit_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the one-hot input width (power of two, >=2).
REQ-002 The block SHALL have derived constant IDX_W, default $clog2(DEPTH), meaning the index width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  the source presents a one-hot word.
REQ-006 in_ready  output  1  the block can accept a word this cycle.
REQ-007 onehot  input  DEPTH  the word to encode.
REQ-008 out_valid  output  1  the head result is valid.
REQ-009 out_ready  input  1  the sink takes the head result.
REQ-010 index  output  IDX_W  the encoded bit position.
REQ-011 zero  output  1  the encoded word had no bit set.
REQ-012 multi  output  1  the encoded word had more than one bit set.
REQ-013 err_count  output  16  the saturating count of accepted malformed words.
REQ-014 clr_count  input  1  synchronous clear of err_count.

Function
REQ-015 A word SHALL be accepted only on a cycle with in_valid && in_ready.
REQ-016 A result SHALL be popped only on a cycle with out_valid && out_ready.
REQ-017 index SHALL be the lowest set bit position of onehot (lowest index wins).
REQ-018 For a zero word, the result SHALL have index=0, zero=1 and multi=0.
REQ-019 For a word with two or more bits set, the result SHALL have index equal to the lowest set bit, multi=1 and zero=0.
REQ-020 Results SHALL be held in a 2-entry FIFO with states EMPTY, ONE and FULL.
REQ-021 The FIFO state transitions SHALL be:
- push only: EMPTY->ONE, ONE->FULL
- pop only: FULL->ONE, ONE->EMPTY
- push and pop together: the state is unchanged.
REQ-022 Latency SHALL be 1 cycle: a word accepted in cycle N is visible as the head with out_valid=1 in cycle N+1 when the FIFO was EMPTY.
REQ-023 in_ready SHALL be 1 whenever the state is not FULL.
REQ-024 in_ready SHALL be fully registered, with no combinational path from out_ready.
REQ-025 Simultaneous push and pop in state ONE SHALL pop the old head and make the new entry the head in the next cycle.
REQ-026 While out_valid=1 and out_ready=0, index, zero and multi SHALL hold stable.
REQ-027 When the state is EMPTY, out_valid SHALL be 0 and index, zero and multi SHALL be 0.
REQ-028 err_count SHALL increment by 1 on each accepted word with zero or multi set, and SHALL saturate at 0xFFFF.
REQ-029 When clr_count=1, err_count SHALL become 0 next cycle, even if a malformed word is accepted in that same cycle (clear wins).
REQ-030 Results SHALL be delivered in acceptance order, with none dropped or duplicated.

Reset
REQ-031 When rst=1 at a clock edge, the FIFO SHALL go to EMPTY and in_ready SHALL become 1, out_valid 0, index 0, zero 0, multi 0 and err_count 0.
REQ-032 A reset asserted mid-operation SHALL discard all buffered results.
REQ-033 rst SHALL take priority over push, pop and clr_count in the same cycle.

Structure
REQ-034 Package hot_bit_pkg SHALL hold the DEPTH default, the IDX_W derivation and a result struct {index, zero, multi}.
REQ-035 The block SHALL instantiate one combinational sub-module, hot_bit_prio_enc (onehot -> index/zero/multi), ahead of the FIFO.

Verification
REQ-036 The bench SHALL cover these directed scenarios with DEPTH=8:
- Basic encode: with out_ready=1, drive onehot=00000001,00000010,...,10000000, one per cycle -> index 0..7 in order, each 1 cycle after acceptance, zero=multi=0, err_count=0.
- Malformed words: drive onehot=00000000, then 00100100 -> results (index 0, zero=1) then (index 2, multi=1), err_count=2.
- Backpressure: hold out_ready=0 and push 00001000, 01000000, 00000010 -> in_ready=0 after 2 accepts, third word held; raise out_ready -> indices 3, 6, 1 in order.
- Saturation and clear: preload 65535 errors, push 00000000 -> err_count stays 0xFFFF; clr_count=1 with a malformed push in the same cycle -> err_count=0.
- Reset mid-operation: FIFO FULL, assert rst for 1 cycle -> out_valid=0, in_ready=1, err_count=0; next push 10000000 -> index 7.
- Simultaneous push and pop in state ONE: head 00010000, push 00000100 with out_ready=1 -> index 4 popped, then index 2 is the head, state stays ONE.
